// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - pipelined instruction fetch sequencer with prefetch FIFO
//
// Purpose: issues instruction-memory reads from a PC register, tracks the
// MEM_LATENCY-cycle return pipe, buffers returned words in a FIFO_DEPTH-entry
// FIFO and hands them to decode over a valid/accept handshake. Supports
// start, halt (with drain of in-flight reads) and branch redirect, which
// kills in-flight reads and flushes the FIFO.
//
// Optional feature macro: FETCH_PERF_CNT_EN (adds fetch_count/stall_count).
//
// Ports:
//   clk, reset              clock (rising edge), async active-low reset
//   start, halt             begin/resume and stop fetching
//   branch_en/target        redirect pc, kill in-flight reads, flush FIFO
//   im_addr/im_rd_en        registered instruction memory read request
//   im_rdata                instruction memory read data
//   ir_valid/ir_data        FIFO head towards decode
//   ir_accept               decode takes ir_data this cycle
//   pc_out                  next address to be fetched
//   fetch_count/stall_count 16-bit saturating counters (FETCH_PERF_CNT_EN)
//   running                 high in RUN state
module fetch_sequencer #(
   parameter int                  IR_width    = 12,
   parameter int                  Im_width    = 8,
   parameter int                  MEM_LATENCY = 1,
   parameter int                  FIFO_DEPTH  = 2,
   parameter logic [Im_width-1:0] PC_RESET    = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                halt,
   input  logic                branch_en,
   input  logic [Im_width-1:0] branch_target,
   output logic [Im_width-1:0] im_addr,
   output logic                im_rd_en,
   input  logic [IR_width-1:0] im_rdata,
   output logic                ir_valid,
   output logic [IR_width-1:0] ir_data,
   input  logic                ir_accept,
   output logic [Im_width-1:0] pc_out,
`ifdef FETCH_PERF_CNT_EN
   output logic [15:0]         fetch_count,
   output logic [15:0]         stall_count,
`endif
   output logic                running
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int SUM_W = $clog2(FIFO_DEPTH + MEM_LATENCY + 2) + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED} state_t;

   state_t                state_q, state_d;
   logic                  running_q;
   logic [Im_width-1:0]   pc_q, pc_d;
   logic [Im_width-1:0]   im_addr_q;
   logic                  im_rd_en_q;
   logic [MEM_LATENCY-1:0] vld_q, vld_d;
   logic [IR_width-1:0]   fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [IR_width-1:0]   ir_data_q, ir_data_d;
   logic [SUM_W-1:0]      inflight, reserved;
   logic                  issue, push, pop;

   // Handshake and issue decision. A read reserves a FIFO slot from issue
   // until it is popped; the slot freed by this cycle's pop is counted as
   // available, which is still exact because pushes can only add words.
   always_comb begin
      pop      = (count_q != '0) && ir_accept && !branch_en;
      push     = vld_q[MEM_LATENCY-1] && !branch_en;
      inflight = SUM_W'(im_rd_en_q);
      for (int i = 0; i < MEM_LATENCY; i++) begin
         inflight = inflight + SUM_W'(vld_q[i]);
      end
      reserved = SUM_W'(count_q) + inflight - SUM_W'(pop);
      issue    = (state_q == S_RUN) && !halt && !branch_en &&
                 (reserved < SUM_W'(FIFO_DEPTH));
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start)          state_d = S_RUN;
         S_RUN:    if (halt)           state_d = S_DRAIN;
         S_DRAIN:  if (inflight == '0) state_d = S_HALTED;
         S_HALTED: if (start && !halt) state_d = S_RUN;
         default:                      state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pc_d = pc_q;
      if (branch_en) begin
         pc_d = branch_target;
      end else if (issue) begin
         pc_d = pc_q + Im_width'(1);
      end

      // The read strobed this cycle enters the tracking pipe next cycle;
      // a branch clears the pipe so killed reads are never pushed.
      vld_d    = vld_q << 1;
      vld_d[0] = im_rd_en_q;
      if (branch_en) begin
         vld_d = '0;
      end

      rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
      rd_ptr_d   = pop ? rd_ptr_nxt : rd_ptr_q;
      wr_ptr_d   = wr_ptr_q + PTR_W'(push);
      count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

      // ir_data is a register so it holds its last value once the FIFO
      // drains; it loads whatever becomes the new head.
      ir_data_d = ir_data_q;
      if (pop) begin
         if (count_q > CNT_W'(1)) begin
            ir_data_d = fifo_q[rd_ptr_nxt];
         end else if (push) begin
            ir_data_d = im_rdata;
         end
      end else if (push && (count_q == '0)) begin
         ir_data_d = im_rdata;
      end

      if (branch_en) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         running_q  <= 1'b0;
         pc_q       <= PC_RESET;
         im_addr_q  <= '0;
         im_rd_en_q <= 1'b0;
         vld_q      <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         ir_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         running_q  <= (state_d == S_RUN);
         pc_q       <= pc_d;
         im_rd_en_q <= issue;
         if (issue) begin
            im_addr_q <= pc_q;
         end
         vld_q      <= vld_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         ir_data_q  <= ir_data_d;
      end
   end

   // FIFO storage needs no reset: count_q alone defines which slots are live.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= im_rdata;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_cnt_q;
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (issue && (fetch_cnt_q != 16'hFFFF)) begin
            fetch_cnt_q <= fetch_cnt_q + 16'd1;
         end
         if ((state_q == S_RUN) && (count_q == '0) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
      end
   end

   assign fetch_count = fetch_cnt_q;
   assign stall_count = stall_cnt_q;
`else
   // Counters are not built in this configuration.
`endif

   assign im_addr  = im_addr_q;
   assign im_rd_en = im_rd_en_q;
   assign ir_valid = (count_q != '0);
   assign ir_data  = ir_data_q;
   assign pc_out   = pc_q;
   assign running  = running_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;

   localparam int LA = 1;
   localparam int DA = 2;
   localparam int LB = 3;
   localparam int DB = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        start_a, halt_a, br_a, acc_a, rd_a, valid_a, run_a;
   logic [7:0]  tgt_a, addr_a, pc_a;
   logic [11:0] rdata_a, data_a;
   logic        start_b, halt_b, br_b, acc_b, rd_b, valid_b, run_b;
   logic [7:0]  tgt_b, addr_b, pc_b;
   logic [11:0] rdata_b, data_b;

   int n_pass = 0;
   int n_total = 0;
   int words_a = 0, words_b = 0, issues_a = 0, issues_b = 0, cyc = 0;
   logic [11:0] q_a[$];
   logic [11:0] q_b[$];
   logic [7:0]  aq_b[$];

   fetch_sequencer #(.MEM_LATENCY(LA), .FIFO_DEPTH(DA)) dut_a (
      .clk(clk), .reset(rst_n), .start(start_a), .halt(halt_a),
      .branch_en(br_a), .branch_target(tgt_a), .im_addr(addr_a),
      .im_rd_en(rd_a), .im_rdata(rdata_a), .ir_valid(valid_a),
      .ir_data(data_a), .ir_accept(acc_a), .pc_out(pc_a), .running(run_a)
   );

   fetch_sequencer #(.MEM_LATENCY(LB), .FIFO_DEPTH(DB)) dut_b (
      .clk(clk), .reset(rst_n), .start(start_b), .halt(halt_b),
      .branch_en(br_b), .branch_target(tgt_b), .im_addr(addr_b),
      .im_rd_en(rd_b), .im_rdata(rdata_b), .ir_valid(valid_b),
      .ir_data(data_b), .ir_accept(acc_b), .pc_out(pc_b), .running(run_b)
   );

   // Memory models: mem[n] = n + 0x100, returned exactly L cycles after the
   // strobe is sampled; 0xBAD on any other cycle.
   logic [11:0] pa[LA];
   logic        va[LA];
   logic [11:0] pb[LB];
   logic        vb[LB];
   always @(posedge clk) begin
      cyc = cyc + 1;
      for (int i = LA - 1; i > 0; i--) begin
         pa[i] <= pa[i-1];
         va[i] <= va[i-1];
      end
      pa[0] <= 12'h100 + 12'(addr_a);
      va[0] <= rd_a;
      for (int j = LB - 1; j > 0; j--) begin
         pb[j] <= pb[j-1];
         vb[j] <= vb[j-1];
      end
      pb[0] <= 12'h100 + 12'(addr_b);
      vb[0] <= rd_b;
   end
   assign rdata_a = (va[LA-1] === 1'b1) ? pa[LA-1] : 12'hBAD;
   assign rdata_b = (vb[LB-1] === 1'b1) ? pb[LB-1] : 12'hBAD;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic fail_none(input string tag, input logic [31:0] obs);
      n_total = n_total + 1;
      $error("FAIL %s observed=%0h expected=nothing", tag, obs);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard pop side: compare on every accepted word / issued read.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (rd_a) issues_a = issues_a + 1;
         if (valid_a && acc_a && !br_a) begin
            if (q_a.size() == 0) fail_none("a_word_unexpected", data_a);
            else chk("a_word", data_a, q_a.pop_front());
            words_a = words_a + 1;
         end
         if (rd_b) begin
            issues_b = issues_b + 1;
            if (aq_b.size() == 0) fail_none("b_issue_unexpected", addr_b);
            else chk("b_issue_addr", addr_b, aq_b.pop_front());
         end
         if (valid_b && acc_b && !br_b) begin
            if (q_b.size() == 0) fail_none("b_word_unexpected", data_b);
            else chk("b_word", data_b, q_b.pop_front());
            words_b = words_b + 1;
         end
      end
   end

   task automatic wait_words_a(input int n);
      int target = words_a + n;
      int k = 0;
      while (words_a < target && k < 200) begin tick(); k++; end
      chk("a_progress", 32'(words_a >= target), 1);
   endtask

   task automatic wait_words_b(input int n);
      int target = words_b + n;
      int k = 0;
      while (words_b < target && k < 200) begin tick(); k++; end
      chk("b_progress", 32'(words_b >= target), 1);
   endtask

   initial begin
      int k;
      int t0;
      logic [7:0] a8;
      rst_n = 1'b0;
      start_a = 0; halt_a = 0; br_a = 0; acc_a = 0; tgt_a = '0;
      start_b = 0; halt_b = 0; br_b = 0; acc_b = 0; tgt_b = '0;
      tick(); tick();
      chk("a_rst_valid", valid_a, 0);
      chk("a_rst_rd_en", rd_a, 0);
      chk("a_rst_addr", addr_a, 0);
      chk("a_rst_data", data_a, 0);
      chk("a_rst_running", run_a, 0);
      chk("a_rst_pc", pc_a, 0);
      chk("b_rst_pc", pc_b, 0);
      rst_n = 1'b1;
      tick();
      chk("a_idle_running", run_a, 0);
      chk("a_idle_rd_en", rd_a, 0);

      // Start with the consumer stalled to see the buffer fill.
      for (int i = 0; i < 64; i++) q_a.push_back(12'h100 + 12'(i));
      start_a = 1; tick(); start_a = 0;
      chk("a_run_entered", run_a, 1);
      chk("a_no_issue_first_run_cycle", rd_a, 0);
      tick();
      chk("a_first_issue", rd_a, 1);
      chk("a_first_addr", addr_a, 0);
      k = 0;
      while (!valid_a && k < 10) begin tick(); k++; end
      chk("a_first_valid", valid_a, 1);
      for (int i = 0; i < 5; i++) begin
         chk("a_stall_valid", valid_a, 1);
         chk("a_stall_data", data_a, 12'h100);
         chk("a_stall_no_issue", rd_a, 0);
         tick();
      end
      chk("a_issued_unaccepted", issues_a, DA);
      acc_a = 1;
      wait_words_a(12);

      // Branch with a read in flight.
      k = 0;
      while (!rd_a && k < 10) begin tick(); k++; end
      chk("a_inflight_before_branch", rd_a, 1);
      br_a = 1; tgt_a = 8'h40;
      q_a.delete();
      for (int i = 0; i < 64; i++) q_a.push_back(12'h140 + 12'(i));
      tick(); br_a = 0;
      chk("a_branch_pc", pc_a, 8'h40);
      chk("a_branch_no_issue", rd_a, 0);
      k = 0;
      while (!rd_a && k < 5) begin tick(); k++; end
      chk("a_branch_issue", rd_a, 1);
      chk("a_branch_addr", addr_a, 8'h40);
      wait_words_a(10);

      // Halt for one cycle, drain, then resume.
      halt_a = 1; tick(); halt_a = 0;
      chk("a_halt_running", run_a, 0);
      chk("a_halt_no_issue", rd_a, 0);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("a_drain_no_issue", rd_a, 0);
      end
      chk("a_halted_empty", valid_a, 0);
      chk("a_halted_pc", pc_a, 8'(q_a[0] - 12'h100));
      chk("a_halted_data_hold", data_a, q_a[0] - 12'd1);
      start_a = 1; tick(); start_a = 0;
      chk("a_resume_running", run_a, 1);
      wait_words_a(10);
      acc_a = 0;

      // Wrap and latency on the deep-latency instance.
      br_b = 1; tgt_b = 8'hFE; tick(); br_b = 0;
      chk("b_idle_branch_pc", pc_b, 8'hFE);
      chk("b_idle_branch_running", run_b, 0);
      chk("b_idle_branch_no_issue", rd_b, 0);
      for (int i = 0; i < 40; i++) begin
         a8 = 8'hFE + 8'(i);
         aq_b.push_back(a8);
         q_b.push_back(12'h100 + 12'(a8));
      end
      start_b = 1; tick(); start_b = 0;
      k = 0;
      while (!rd_b && k < 5) begin tick(); k++; end
      chk("b_first_issue", rd_b, 1);
      t0 = cyc;
      k = 0;
      while (!valid_b && k < 10) begin tick(); k++; end
      chk("b_issue_to_valid", 32'(cyc - t0), LB + 1);
      repeat (6) tick();
      chk("b_issued_full", issues_b, DB);
      chk("b_addr_left", aq_b.size(), 36);
      chk("b_head_data", data_b, 12'h1FE);
      acc_b = 1;
      wait_words_b(12);
      acc_b = 0;

      // Asynchronous reset between clock edges with words buffered.
      chk("a_pre_reset_valid", valid_a, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("a_async_valid", valid_a, 0);
      chk("a_async_pc", pc_a, 0);
      chk("a_async_rd_en", rd_a, 0);
      chk("a_async_running", run_a, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
